// File: rtl/count_seq_pkg.sv
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared opcodes, FSM states and default widths for the
//               count_sequencer command controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_seq_pkg;

  localparam int COUNT_W = 5;
  localparam int STEP_W  = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_RUN  = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/count_sequencer_if.sv
// ============================================================================
// Module      : count_sequencer_if
// Description : Command handshake plus counter-drive bundle between a command
//               source (master) and the count_sequencer (slave).
//               COUNT_SEQ_WRAP_FLAG_EN adds the wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface count_sequencer_if #(
  parameter int WIDTH  = count_seq_pkg::COUNT_W,
  parameter int STEP_W = count_seq_pkg::STEP_W
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  count_seq_pkg::cmd_op_e cmd_op;
  logic [STEP_W-1:0]     cmd_arg;
  logic                  abort;
  logic [WIDTH-1:0]      data;
  logic                  load;
  logic                  enable;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      shadow;
`ifdef COUNT_SEQ_WRAP_FLAG_EN
  logic                  wrap;
`endif

  modport master (
    output cmd_valid, cmd_op, cmd_arg, abort,
`ifdef COUNT_SEQ_WRAP_FLAG_EN
    input  wrap,
`endif
    input  cmd_ready, data, load, enable, busy, done, shadow
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, abort,
`ifdef COUNT_SEQ_WRAP_FLAG_EN
    output wrap,
`endif
    output cmd_ready, data, load, enable, busy, done, shadow
  );

endinterface

`default_nettype wire

// File: rtl/count_sequencer.sv
// ============================================================================
// Module      : count_sequencer
// Description : Drives data/load/enable of a loadable up-counter from LOAD and
//               RUN commands, tracking the expected count in a shadow register.
//               Optional COUNT_SEQ_WRAP_FLAG_EN adds a registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sequencer #(
  parameter int WIDTH  = count_seq_pkg::COUNT_W,
  parameter int STEP_W = count_seq_pkg::STEP_W
) (
  input wire logic          clk,
  input wire logic          rst,
  count_sequencer_if.slave  cmd_if
);

  import count_seq_pkg::*;

  seq_state_e        state_q,  state_d;
  logic [WIDTH-1:0]  data_q,   data_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [STEP_W-1:0] step_q,   step_d;
  logic              load_q,   load_d;
  logic              enable_q, enable_d;
  logic              done_q,   done_d;
  logic              accept_w;

  assign cmd_if.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept_w         = cmd_if.cmd_valid && cmd_if.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      shadow_q <= '0;
      step_q   <= '0;
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      step_q   <= step_d;
      load_q   <= load_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  // Strobes are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    step_d   = step_q;
    load_d   = 1'b0;
    enable_d = 1'b0;
    done_d   = 1'b0;
    shadow_d = enable_q ? shadow_q + WIDTH'(1) : shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          case (cmd_if.cmd_op)
            OP_LOAD: begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
              data_d  = cmd_if.cmd_arg[WIDTH-1:0];
            end
            OP_RUN: begin
              if (cmd_if.cmd_arg == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d  = ST_RUN;
                enable_d = 1'b1;
                step_d   = cmd_if.cmd_arg;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        shadow_d = data_q;
        state_d  = ST_DONE;
        done_d   = 1'b1;
      end
      ST_RUN: begin
        step_d = step_q - STEP_W'(1);
        if (cmd_if.abort || (step_q == STEP_W'(1))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          enable_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef COUNT_SEQ_WRAP_FLAG_EN
  logic wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= enable_q && (shadow_q == '1);
    end
  end

  assign cmd_if.wrap = wrap_q;
`endif

  assign cmd_if.data   = data_q;
  assign cmd_if.load   = load_q;
  assign cmd_if.enable = enable_q;
  assign cmd_if.done   = done_q;
  assign cmd_if.shadow = shadow_q;
  assign cmd_if.busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/count_sequencer.md
# count_sequencer

Command-driven controller that sits directly upstream of the 5-bit loadable up-counter and generates its `data`, `load` and `enable` inputs. It accepts LOAD and RUN commands over a valid/ready handshake. It then issues one load pulse or exactly N enable cycles, and keeps a shadow copy of the counter value so downstream logic can read the expected count without tapping the counter. A `done` pulse marks command completion.

## Interface
- `WIDTH`, default 5: counter width; `data` and `shadow` width.
- `STEP_W`, default 8: width of `cmd_arg` and of the internal step counter.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  2: command opcode.
  - 2'b00 NOP.
  - 2'b01 LOAD.
  - 2'b10 RUN.
  - 2'b11 reserved, treated as NOP.
- `cmd_arg`  in  STEP_W: LOAD uses the value in `cmd_arg[WIDTH-1:0]`. RUN uses the full field as the step count N.
- `abort`  in  1: terminate a RUN early.
- `data`  out  WIDTH: load value to the counter.
- `load`  out  1: counter load strobe.
- `enable`  out  1: counter increment enable.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle completion pulse.
- `shadow`  out  WIDTH: expected counter value.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- `cmd_ready` is 1 only in IDLE, and is forced to 0 while `rst` is high.
- A command is accepted on a rising edge where `cmd_valid & cmd_ready`.
- IDLE:
  - LOAD accepted: go to LOAD and register `data` = `cmd_arg[WIDTH-1:0]`.
  - RUN with N>0: go to RUN and set the step counter to N.
  - RUN with N=0: go straight to DONE; `enable` is never asserted.
  - NOP or reserved: accepted and consumed; stay in IDLE; no `done`.
- LOAD: `load`=1 for exactly one cycle; `shadow` takes `data` at the end of that cycle; then go to DONE.
- RUN: `enable`=1 every cycle; the step counter decrements each cycle; `shadow` increments modulo 2^WIDTH each cycle (31→0 wraps silently); go to DONE after N cycles.
- Abort: `abort` sampled high in RUN forces DONE at that edge. `enable` is low from the next cycle and `shadow` counts only the cycles where `enable` was actually high. `abort` is ignored outside RUN.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `load` and `enable` are never high in the same cycle. The downstream counter gives load priority, but the sequencer does not rely on that.
- `data` holds its last loaded value outside LOAD.

## Timing
- `data`, `load`, `enable`, `done` and `shadow` are registered outputs. `busy` and `cmd_ready` decode from the registered state.
- Reset values: state IDLE; `data`, `load`, `enable`, `done`, `busy` and `shadow` all 0; step counter 0.
- LOAD accepted at edge k:
  - `load` high in cycle k..k+1.
  - `done` high in cycle k+1..k+2.
  - `cmd_ready` high again from edge k+2.
- RUN N accepted at edge k:
  - `enable` high for exactly N cycles, edges k+1..k+N.
  - `done` high in the following cycle.
  - Total occupancy N+2 cycles.
- Back-to-back commands: the minimum spacing between acceptances is 3 cycles for LOAD and N+2 cycles for RUN.
- Reset mid-operation: at the reset edge every output drops to its reset value. No `done` is emitted. The pending command is discarded.
- `rst` and `cmd_valid` high together: reset wins and no command is accepted.

## Configuration
- `COUNT_SEQ_WRAP_FLAG_EN` defined:
  - Adds output `wrap` (1 bit, reset 0), registered.
  - `wrap` pulses for one cycle when `shadow` goes from all-ones to 0 because of an enable cycle.
  - A LOAD of 0 does not set `wrap`.
- `COUNT_SEQ_WRAP_FLAG_EN` not defined: the `wrap` port and its logic are absent; all other behaviour is identical.

## Structure
- Package `count_seq_pkg` contains:
  - Opcode enum `cmd_op_e` (OP_NOP, OP_LOAD, OP_RUN, OP_RSVD).
  - State enum `seq_state_e`.
  - Default constants `COUNT_W`=5 and `STEP_W`=8.
- No sub-module: the step down-counter and the shadow register stay inline.
- The bench pairs this block with the existing counter and checks `shadow` == `count` on every cycle.

## Test plan
- Reset, then LOAD 5'd17: `load` pulses for one cycle with `data`=17; `done` one cycle later; `shadow`=17 and counter `count`=17.
- LOAD 5, then RUN 3: exactly 3 `enable` cycles; `shadow` steps 6, 7, 8; one `done`; `cmd_ready` returns.
- LOAD 30, then RUN 4: `shadow` steps 31, 0, 1, 2; with `COUNT_SEQ_WRAP_FLAG_EN`, `wrap` pulses once on the 31→0 step.
- RUN 0 and NOP: RUN 0 gives no `enable` and `done` one cycle after acceptance; NOP gives no `done` and `cmd_ready` stays 1.
- RUN 200 with `abort` after the 10th enable cycle: exactly 10 increments, then `done`; `cmd_valid` is ignored while `busy`.
- `rst` asserted mid-RUN: outputs go to zero on the next edge, no `done`, `cmd_ready` is 1 the cycle after `rst` falls.
